instr_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the 32-bit processor core.
- Drives the instruction-memory handshake and latches the fetched word.
- Decodes opcode[31:24] and issues one-cycle enables to the PC, ALU, data memory and register file.
- Sits between instruction memory and the existing PC/ALU/regfile datapath; the PC register is owned elsewhere and obeys pc_inc / pc_load / pc_target.

---
 rtl/instr_seq_ctrl_pkg.sv | 43 ++++
 rtl/instr_seq_ctrl_class_dec.sv | 26 ++
 rtl/instr_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_instr_seq_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_seq_ctrl_pkg.sv
// Shared opcode map, FSM state encoding and decoded instruction-class type
// for the instruction sequencer.
package instr_seq_ctrl_pkg;

  localparam logic [7:0] OP_JMP   = 8'h01;
  localparam logic [7:0] OP_JMPE  = 8'h02;
  localparam logic [7:0] OP_JMPNE = 8'h03;
  localparam logic [7:0] OP_HLT   = 8'h0F;
  localparam logic [7:0] OP_LOAD  = 8'h10;
  localparam logic [7:0] OP_STORE = 8'h11;

  // ALU opcodes occupy 8'h20..8'h27: ADD SUB AND OR XOR SHL SHR CMP
  localparam logic [7:0] OP_ADD   = 8'h20;
  localparam logic [7:0] OP_CMP   = 8'h27;

  localparam int LAT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef struct packed {
    logic jmp;
    logic jmpe;
    logic jmpne;
    logic hlt;
    logic ld;
    logic st;
    logic alu;
    logic nop;
  } iclass_t;

  function automatic logic is_alu_op(input logic [7:0] op);
    return (op >= OP_ADD) && (op <= OP_CMP);
  endfunction

endpackage

// File: rtl/instr_seq_ctrl_class_dec.sv
// Combinational opcode classifier: maps ir[31:24] to a one-hot instruction class.
// Any opcode outside the defined set decodes as NOP.
module instr_class_dec
  import instr_seq_ctrl_pkg::*;
(
  input  logic [7:0] opcode_i,
  output iclass_t    cls_o
);

  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OP_JMP:   cls_o.jmp   = 1'b1;
      OP_JMPE:  cls_o.jmpe  = 1'b1;
      OP_JMPNE: cls_o.jmpne = 1'b1;
      OP_HLT:   cls_o.hlt   = 1'b1;
      OP_LOAD:  cls_o.ld    = 1'b1;
      OP_STORE: cls_o.st    = 1'b1;
      default: begin
        if (is_alu_op(opcode_i)) cls_o.alu = 1'b1;
        else                     cls_o.nop = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle fetch/decode/exec sequencer; strobes are Mealy outputs of the current state,
// fetch and data accesses stall on their acks. Optional perf counters: INSTR_SEQ_PERF_EN.
module instr_seq_ctrl
  import instr_seq_ctrl_pkg::*;
#(
  parameter int ALU_LAT = 1
`ifdef INSTR_SEQ_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  input  logic        ZF,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [23:0] pc_target,
  output logic        alu_en,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        halted
`ifdef INSTR_SEQ_PERF_EN
  , output logic [CNT_W-1:0] cycle_cnt
  , output logic [CNT_W-1:0] retired_cnt
`endif
);

  state_e            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  iclass_t           cls;

  instr_class_dec u_class_dec (
    .opcode_i (ir_q[31:24]),
    .cls_o    (cls)
  );

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    lat_d    = lat_q;
    imem_req = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    alu_en   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_FETCH;
        if (cls.jmp) begin
          pc_load = 1'b1;
        end else if (cls.jmpe) begin
          pc_load = ZF;
          pc_inc  = !ZF;
        end else if (cls.jmpne) begin
          pc_load = !ZF;
          pc_inc  = ZF;
        end else if (cls.hlt) begin
          state_d = S_HALT;
        end else if (cls.ld || cls.st) begin
          state_d = S_MEM;
        end else if (cls.alu) begin
          // Counter is preloaded so EXEC lasts exactly ALU_LAT cycles.
          lat_d   = LAT_W'(ALU_LAT - 1);
          state_d = S_EXEC;
        end else if (cls.nop) begin
          pc_inc = 1'b1;
        end
      end
      S_EXEC: begin
        alu_en = 1'b1;
        if (lat_q == '0) state_d = S_WB;
        else             lat_d   = lat_q - 1'b1;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cls.st;
        if (dmem_ack) begin
          if (cls.st) begin
            pc_inc  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_inc  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      lat_q   <= lat_d;
    end
  end

  assign ir        = ir_q;
  assign pc_target = ir_q[23:0];

`ifdef INSTR_SEQ_PERF_EN
  logic [CNT_W-1:0] cyc_q, ret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_HALT) cyc_q <= cyc_q + CNT_W'(1);
      if (pc_inc || pc_load)                      ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cyc_q;
  assign retired_cnt = ret_q;
`endif

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Bench for instr_seq_ctrl: per-instruction expected cycle schedules built from the
// latency rules, compared against the DUT every cycle, with randomized program and waits.
module tb_instr_seq_ctrl;
  import instr_seq_ctrl_pkg::*;

  localparam int ALU_LAT = 3;
`ifdef INSTR_SEQ_PERF_EN
  localparam int CNT_W = 8;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        ZF = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, pc_inc, pc_load, alu_en, dmem_req, dmem_we, rf_we, halted;
  logic [31:0] ir;
  logic [23:0] pc_target;
`ifdef INSTR_SEQ_PERF_EN
  logic [CNT_W-1:0] cycle_cnt, retired_cnt;
  int m_cyc = 0;
  int m_ret = 0;
`endif

  always #5 clk = ~clk;

  instr_seq_ctrl #(
    .ALU_LAT(ALU_LAT)
`ifdef INSTR_SEQ_PERF_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir),
    .ZF(ZF), .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target),
    .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .halted(halted)
`ifdef INSTR_SEQ_PERF_EN
    , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
  );

  typedef struct packed {
    logic busy;
    logic imem_req;
    logic pc_inc;
    logic pc_load;
    logic alu_en;
    logic dmem_req;
    logic dmem_we;
    logic rf_we;
    logic halted;
  } exp_t;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] m_ir = '0;

  function automatic logic rb();
    return 1'($urandom_range(1));
  endfunction

  // 0 jmp, 1 jmpe, 2 jmpne, 3 hlt, 4 load, 5 store, 6 alu, 7 nop
  function automatic int cls_of(input logic [7:0] op);
    if (op == OP_JMP)   return 0;
    if (op == OP_JMPE)  return 1;
    if (op == OP_JMPNE) return 2;
    if (op == OP_HLT)   return 3;
    if (op == OP_LOAD)  return 4;
    if (op == OP_STORE) return 5;
    if (op >= 8'h20 && op <= 8'h27) return 6;
    return 7;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h at t=%0t", name, act, req, $time);
  endtask

  // One clock cycle: drive inputs, compare outputs, advance, update model.
  task automatic cyc(input exp_t e, input logic iack, input logic [31:0] rdata,
                     input logic dack, input logic zf, input logic st, input logic rst);
    imem_ack = iack; imem_rdata = rdata; dmem_ack = dack; ZF = zf; start = st; reset = rst;
    #1;
    chk("outputs", 32'({imem_req, pc_inc, pc_load, alu_en, dmem_req, dmem_we, rf_we, halted}),
        32'(e[7:0]));
    chk("ir", ir, m_ir);
    chk("pc_target", 32'(pc_target), 32'(m_ir[23:0]));
`ifdef INSTR_SEQ_PERF_EN
    chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cyc % 256));
    chk("retired_cnt", 32'(retired_cnt), 32'(m_ret % 256));
`endif
    @(posedge clk); #1;
    if (rst) begin
      m_ir = '0;
`ifdef INSTR_SEQ_PERF_EN
      m_cyc = 0; m_ret = 0;
`endif
    end else begin
      if (iack && e.imem_req) m_ir = rdata;
`ifdef INSTR_SEQ_PERF_EN
      m_cyc += int'(e.busy);
      m_ret += int'(e.pc_inc | e.pc_load);
`endif
    end
  endtask

  task automatic idle_start(input int n);
    exp_t e;
    e = '0;
    for (int i = 0; i < n; i++) cyc(e, rb(), $urandom, rb(), rb(), 1'b0, 1'b0);
    cyc(e, rb(), $urandom, rb(), rb(), 1'b1, 1'b0);
  endtask

  // Runs one instruction from FETCH; len counts cycles until the next FETCH.
  task automatic run_instr(input logic [31:0] w, input int wf, input int wd,
                           input logic zf, output int len);
    exp_t e;
    int   c;
    len = 0;
    e = '0; e.busy = 1'b1; e.imem_req = 1'b1;
    for (int i = 0; i < wf; i++) begin
      cyc(e, 1'b0, $urandom, rb(), rb(), rb(), 1'b0); len++;
    end
    cyc(e, 1'b1, w, rb(), rb(), rb(), 1'b0); len++;
    c = cls_of(w[31:24]);
    e = '0; e.busy = 1'b1;
    case (c)
      0: e.pc_load = 1'b1;
      1: begin e.pc_load = zf;  e.pc_inc = !zf; end
      2: begin e.pc_load = !zf; e.pc_inc = zf;  end
      7: e.pc_inc = 1'b1;
      default: ;
    endcase
    cyc(e, rb(), $urandom, rb(), zf, rb(), 1'b0); len++;
    if (c == 6) begin
      e = '0; e.busy = 1'b1; e.alu_en = 1'b1;
      for (int i = 0; i < ALU_LAT; i++) begin
        cyc(e, rb(), $urandom, rb(), rb(), rb(), 1'b0); len++;
      end
      e = '0; e.busy = 1'b1; e.rf_we = 1'b1; e.pc_inc = 1'b1;
      cyc(e, rb(), $urandom, rb(), rb(), rb(), 1'b0); len++;
    end
    if (c == 4 || c == 5) begin
      e = '0; e.busy = 1'b1; e.dmem_req = 1'b1; e.dmem_we = (c == 5);
      for (int i = 0; i < wd; i++) begin
        cyc(e, rb(), $urandom, 1'b0, rb(), rb(), 1'b0); len++;
      end
      e.pc_inc = (c == 5);
      cyc(e, rb(), $urandom, 1'b1, rb(), rb(), 1'b0); len++;
      if (c == 4) begin
        e = '0; e.busy = 1'b1; e.rf_we = 1'b1; e.pc_inc = 1'b1;
        cyc(e, rb(), $urandom, rb(), rb(), rb(), 1'b0); len++;
      end
    end
    if (c == 3) begin
      e = '0; e.halted = 1'b1;
      for (int i = 0; i < 20; i++) cyc(e, rb(), $urandom, rb(), rb(), rb(), 1'b0);
      cyc(e, rb(), $urandom, rb(), rb(), rb(), 1'b1);
      idle_start(2);
    end
  endtask

  function automatic logic [7:0] pick_op();
    if ($urandom_range(39) == 0) return OP_HLT;
    case ($urandom_range(8))
      0: return OP_JMP;
      1: return OP_JMPE;
      2: return OP_JMPNE;
      3: return OP_LOAD;
      4: return OP_STORE;
      5, 6: return OP_ADD + 8'($urandom_range(7));
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    exp_t e;
    int   len;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    e = '0;
    cyc(e, 1'b1, $urandom, rb(), rb(), rb(), 1'b1);
    idle_start(2);

    run_instr({OP_JMP, 24'h000010}, 0, 0, 1'b0, len);
    chk("jmp_latency", 32'(len), 32'd2);
    chk("jmp_target", 32'(pc_target), 32'h000010);
    run_instr({OP_JMPE, 24'h000020}, 0, 0, 1'b0, len);
    run_instr({OP_JMPE, 24'h000020}, 0, 0, 1'b1, len);
    chk("jmpe_target", 32'(pc_target), 32'h000020);
    run_instr({OP_JMPNE, 24'h000030}, 1, 0, 1'b0, len);
    run_instr({OP_ADD, 24'h000001}, 0, 0, 1'b0, len);
    chk("alu_latency", 32'(len), 32'd6);
    run_instr({OP_STORE, 24'h000002}, 0, 4, 1'b0, len);
    chk("store_wait_latency", 32'(len), 32'd7);
    run_instr({OP_STORE, 24'h000003}, 0, 0, 1'b0, len);
    chk("store_latency", 32'(len), 32'd3);
    run_instr({OP_LOAD, 24'h000004}, 0, 0, 1'b0, len);
    chk("load_latency", 32'(len), 32'd4);
    run_instr({8'hEE, 24'h000005}, 0, 0, 1'b0, len);
    chk("nop_latency", 32'(len), 32'd2);

    // Reset while a fetch ack is on the bus.
    e = '0; e.busy = 1'b1; e.imem_req = 1'b1;
    cyc(e, 1'b0, $urandom, rb(), rb(), rb(), 1'b0);
    cyc(e, 1'b1, 32'hDEADBEEF, rb(), rb(), rb(), 1'b1);
    idle_start(3);

    for (int i = 0; i < 200; i++)
      run_instr({pick_op(), 24'($urandom)}, $urandom_range(2), $urandom_range(3), rb(), len);

    run_instr({OP_HLT, 24'h0}, 0, 0, 1'b0, len);
    run_instr({OP_JMP, 24'h000040}, 0, 0, 1'b0, len);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
